// File: rtl/phasegen_if.sv
// phasegen_if: front-panel and controller bundle for phasegen.
// The breakpoint signals exist only when PHASEGEN_BREAK_EN is defined.
interface phasegen_if #(parameter int CNT_WIDTH = 32);
    logic                 run;
    logic                 stop;
    logic                 step_phase;
    logic                 step_inst;
    logic                 cont;
    logic [3:0]           cstate;
    logic [3:0]           phase;
    logic                 running;
    logic                 inst_done;
    logic [CNT_WIDTH-1:0] inst_cnt;
`ifdef PHASEGEN_BREAK_EN
    logic                 bp_en;
    logic [31:0]          bp_addr;
    logic [31:0]          pc;
    logic                 bp_hit;
    modport master (
        output run, stop, step_phase, step_inst, cont, bp_en, bp_addr, pc,
        input  cstate, phase, running, inst_done, inst_cnt, bp_hit
    );
    modport slave (
        input  run, stop, step_phase, step_inst, cont, bp_en, bp_addr, pc,
        output cstate, phase, running, inst_done, inst_cnt, bp_hit
    );
`else
    modport master (
        output run, stop, step_phase, step_inst, cont,
        input  cstate, phase, running, inst_done, inst_cnt
    );
    modport slave (
        input  run, stop, step_phase, step_inst, cont,
        output cstate, phase, running, inst_done, inst_cnt
    );
`endif
endinterface

// File: rtl/phasegen.sv
// phasegen: one-hot IF/DE/EX/WB phase sequencer with phase/instruction/continuous run modes.
// Defining PHASEGEN_BREAK_EN adds a PC breakpoint that halts continuous run at IF.
module phasegen #(
    parameter int CNT_WIDTH = 32
) (
    input logic       clock,
    input logic       reset,
    phasegen_if.slave pg_io
);
    typedef enum logic [1:0] {S_IDLE, S_PHASE, S_INST, S_CONT} state_e;
    localparam logic [3:0] PH_IF = 4'b0001;
    localparam logic [3:0] PH_WB = 4'b1000;

    state_e               state_q, state_d, sel_mode;
    logic [3:0]           phase_q, phase_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 running, in_wb, start, bp_stop;

    assign running  = state_q != S_IDLE;
    assign in_wb    = phase_q == PH_WB;
    assign start    = !running && pg_io.run && (pg_io.step_phase || pg_io.step_inst || pg_io.cont);
    assign sel_mode = pg_io.step_phase ? S_PHASE : pg_io.step_inst ? S_INST : S_CONT;

`ifdef PHASEGEN_BREAK_EN
    logic first_q, bp_hit_q;
    // The first active cycle after a start is exempt so a run can resume past the breakpoint.
    assign bp_stop = state_q == S_CONT && phase_q == PH_IF && pg_io.bp_en &&
                     pg_io.pc == pg_io.bp_addr && !first_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            first_q  <= start;
            bp_hit_q <= bp_stop || (bp_hit_q && !start);
        end
    end
    assign pg_io.bp_hit = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_IF;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q || (running && pg_io.stop);
        phase_d     = running && !bp_stop ? {phase_q[2:0], phase_q[3]} : phase_q;
        cnt_d       = cnt_q + CNT_WIDTH'(running && in_wb);
        case (state_q)
            S_IDLE: begin
                state_d     = start ? sel_mode : S_IDLE;
                stop_pend_d = start && pg_io.stop;
            end
            S_PHASE: state_d = S_IDLE;
            S_INST:  state_d = in_wb ? S_IDLE : S_INST;
            default: state_d = bp_stop || (in_wb && stop_pend_d) ? S_IDLE : S_CONT;
        endcase
        if (state_d == S_IDLE)
            stop_pend_d = 1'b0;
    end

    always_comb begin
        pg_io.cstate    = running && !bp_stop ? phase_q : 4'b0000;
        pg_io.inst_done = running && in_wb;
    end

    assign pg_io.phase    = phase_q;
    assign pg_io.running  = running;
    assign pg_io.inst_cnt = cnt_q;
endmodule

// File: tb/tb_phasegen.sv
// tb_phasegen: directed stimulus for phasegen, checked every cycle against a behavioural model.
module tb_phasegen;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    phasegen_if #(.CNT_WIDTH(CW)) bus();
    phasegen #(.CNT_WIDTH(CW)) dut (.clock(clock), .reset(reset), .pg_io(bus));

    always #5 clock = ~clock;

`ifdef PHASEGEN_BREAK_EN
    bit pc_ld = 1'b1;
    always @(posedge clock)
        if (pc_ld) bus.pc <= 32'h8;
        else if (bus.inst_done) bus.pc <= bus.pc + 32'd4;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Model: phase index 0..3 (IF..WB), mode 0 none / 1 phase / 2 inst / 3 cont.
    int             m_ph, m_mode;
    bit             m_run, m_sp, m_first, m_hit, m_wb;
    logic [CW-1:0]  m_cnt;

    function automatic bit m_bp();
`ifdef PHASEGEN_BREAK_EN
        return m_run && m_mode == 3 && m_ph == 0 && bus.bp_en && bus.pc == bus.bp_addr && !m_first;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ph = 0; m_run = 0; m_mode = 0; m_sp = 0; m_cnt = '0; m_first = 0; m_hit = 0;
        end else if (!m_run) begin
            m_first = 0;
            if (bus.run && (bus.step_phase || bus.step_inst || bus.cont)) begin
                m_run = 1; m_first = 1; m_hit = 0; m_sp = bus.stop;
                m_mode = bus.step_phase ? 1 : bus.step_inst ? 2 : 3;
            end
        end else if (m_bp()) begin
            m_run = 0; m_hit = 1; m_first = 0; m_sp = 0; m_mode = 0;
        end else begin
            m_first = 0;
            m_wb = m_ph == 3;
            if (m_wb) m_cnt++;
            m_ph = (m_ph + 1) % 4;
            m_sp = m_sp || (m_mode == 3 && bus.stop);
            if (m_mode == 1 || (m_mode == 2 && m_wb) || (m_mode == 3 && m_wb && m_sp)) begin
                m_run = 0; m_mode = 0; m_sp = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cstate", 32'(bus.cstate), (m_run && !m_bp()) ? 32'(1 << m_ph) : 32'd0);
            check("phase", 32'(bus.phase), 32'(1 << m_ph));
            check("running", 32'(bus.running), 32'(m_run));
            check("inst_done", 32'(bus.inst_done), 32'(m_run && m_ph == 3));
            check("inst_cnt", 32'(bus.inst_cnt), 32'(m_cnt));
`ifdef PHASEGEN_BREAK_EN
            check("bp_hit", 32'(bus.bp_hit), 32'(m_hit));
`endif
        end
    end

    initial begin
        int act;
        bus.run = 0; bus.stop = 0; bus.step_phase = 0; bus.step_inst = 0; bus.cont = 0;
`ifdef PHASEGEN_BREAK_EN
        bus.bp_en = 0; bus.bp_addr = 32'h0;
`endif
        #1 reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        chk_en = 1'b1;
        check("rst_cstate", 32'(bus.cstate), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h1);
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_cnt", 32'(bus.inst_cnt), 32'h0);
        // Reset asserted mid-EX of the second instruction in continuous mode
        bus.cont = 1; bus.run = 1; tick(); bus.run = 0; bus.cont = 0;
        check("t1_first_if", 32'(bus.cstate), 32'h1);
        repeat (6) tick();
        check("t1_ex", 32'(bus.cstate), 32'h4);
        check("t1_cnt", 32'(bus.inst_cnt), 32'h1);
        reset = 1'b0;
        #1;
        check("t1_async_cstate", 32'(bus.cstate), 32'h0);
        check("t1_async_phase", 32'(bus.phase), 32'h1);
        check("t1_async_running", 32'(bus.running), 32'h0);
        check("t1_async_cnt", 32'(bus.inst_cnt), 32'h0);
        tick();
        reset = 1'b1;
        // Single phase step
        bus.step_phase = 1; bus.run = 1; tick(); bus.run = 0; bus.step_phase = 0;
        check("t2_active", 32'(bus.cstate), 32'h1);
        tick();
        check("t2_cstate", 32'(bus.cstate), 32'h0);
        check("t2_phase", 32'(bus.phase), 32'h2);
        check("t2_cnt", 32'(bus.inst_cnt), 32'h0);
        // Instruction step from mid-instruction
        bus.step_inst = 1; bus.run = 1; tick(); bus.run = 0; bus.step_inst = 0;
        for (int i = 0; i < 4; i++) begin
            check("t3_cstate", 32'(bus.cstate), i < 3 ? 32'(2 << i) : 32'h0);
            check("t3_done", 32'(bus.inst_done), 32'(i == 2));
            tick();
        end
        check("t3_phase", 32'(bus.phase), 32'h1);
        check("t3_cnt", 32'(bus.inst_cnt), 32'h1);
        bus.run = 1; tick(); bus.run = 0;
        check("nomode_running", 32'(bus.running), 32'h0);
        // Continuous run, 10 instructions, stop during DE
        reset = 1'b0; tick(); reset = 1'b1;
        bus.cont = 1; bus.run = 1; tick(); bus.run = 0; bus.cont = 0;
        repeat (20) tick();
        bus.step_phase = 1; bus.run = 1; tick(); bus.run = 0; bus.step_phase = 0;
        repeat (19) tick();
        check("t4_cnt10", 32'(bus.inst_cnt), 32'd10);
        check("t4_if", 32'(bus.cstate), 32'h1);
        tick();
        bus.stop = 1; tick(); bus.stop = 0;
        check("t4_ex_running", 32'(bus.running), 32'h1);
        tick();
        check("t4_wb", 32'(bus.cstate), 32'h8);
        tick();
        check("t4_running", 32'(bus.running), 32'h0);
        check("t4_phase", 32'(bus.phase), 32'h1);
        check("t4_cnt", 32'(bus.inst_cnt), 32'd11);
        // Stop arriving during WB ends at that same WB
        bus.cont = 1; bus.run = 1; tick(); bus.run = 0; bus.cont = 0;
        tick(); tick(); tick();
        bus.stop = 1; tick(); bus.stop = 0;
        check("wbstop_running", 32'(bus.running), 32'h0);
        check("wbstop_cnt", 32'(bus.inst_cnt), 32'd12);
        // Simultaneous run and stop while idle
        bus.cont = 1; bus.run = 1; bus.stop = 1; tick(); bus.run = 0; bus.stop = 0; bus.cont = 0;
        act = 0;
        repeat (6) begin
            if (bus.cstate != 4'b0000) act++;
            tick();
        end
        check("t5_active", 32'(act), 32'd4);
        check("t5_cnt", 32'(bus.inst_cnt), 32'd13);
        // Counter wrap on the narrow bench counter
        bus.cont = 1; bus.run = 1; tick(); bus.run = 0; bus.cont = 0;
        repeat (8) tick();
        bus.stop = 1; tick(); bus.stop = 0;
        tick(); tick();
        check("wrap_pre", 32'(bus.inst_cnt), 32'd15);
        tick();
        check("wrap_cnt", 32'(bus.inst_cnt), 32'd0);
        check("wrap_running", 32'(bus.running), 32'h0);
`ifdef PHASEGEN_BREAK_EN
        // Breakpoint at pc 0x10, then resume past it
        pc_ld = 0; bus.bp_en = 1; bus.bp_addr = 32'h10;
        bus.cont = 1; bus.run = 1; tick(); bus.run = 0; bus.cont = 0;
        check("bp_first_if", 32'(bus.cstate), 32'h1);
        repeat (8) tick();
        check("bp_cstate", 32'(bus.cstate), 32'h0);
        check("bp_phase_if", 32'(bus.phase), 32'h1);
        tick();
        check("bp_running", 32'(bus.running), 32'h0);
        check("bp_hit", 32'(bus.bp_hit), 32'h1);
        check("bp_phase", 32'(bus.phase), 32'h1);
        bus.cont = 1; bus.run = 1; tick(); bus.run = 0; bus.cont = 0;
        check("bp_resume_cstate", 32'(bus.cstate), 32'h1);
        check("bp_resume_hit", 32'(bus.bp_hit), 32'h0);
        bus.stop = 1; tick(); bus.stop = 0;
        repeat (3) tick();
        check("bp_end_running", 32'(bus.running), 32'h0);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/phasegen.md
Name: phasegen

Overview:
- Phase sequencer for the kappa3 light multi-cycle RISC-V core.
- Generates the one-hot 4-bit `cstate` consumed by the controller: IF=4'b0001, DE=4'b0010, EX=4'b0100, WB=4'b1000.
- Supports continuous run, single-phase step and single-instruction step from the front panel, plus a retired-instruction counter.
- When not running, drives `cstate` = 4'b0000 so the controller asserts no load or write strobes.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter inst_cnt

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  start request, 1-cycle pulse
stop  input  1  stop request, 1-cycle pulse
step_phase  input  1  mode select level: execute one phase
step_inst  input  1  mode select level: execute one instruction
cont  input  1  mode select level: continuous run
cstate  output  4  phase to controller; 4'b0000 when not running
phase  output  4  raw internal phase register (panel display)
running  output  1  sequencer active
inst_done  output  1  high during a running WB cycle
inst_cnt  output  CNT_WIDTH  count of completed WB cycles, wraps

Behaviour:
- Reset (asynchronous, active-low): phase=4'b0001, running=0, mode=NONE, stop_pend=0, inst_cnt=0. Therefore cstate=0 and inst_done=0. Reset mid-instruction abandons the instruction; no partial WB is counted.
- Outputs:
  - cstate = running ? phase : 4'b0000 (combinational).
  - inst_done = running & (phase==WB).
- FSM state is (running, mode ∈ {NONE, PHASE, INST, CONT}).
- IDLE (running=0):
  - phase holds.
  - A run pulse samples the mode levels with priority step_phase > step_inst > cont.
  - The selected mode is latched and running=1 from the next cycle.
  - run with no mode level set: no effect.
  - stop while idle: ignored, unless it coincides with run. In that case, start and set stop_pend.
- RUN: every cycle phase rotates IF→DE→EX→WB→IF; latency from run pulse to first active cstate is 1 cycle.
  - PHASE mode: exactly one active cycle. running clears at the end of that cycle and phase advances once.
  - INST mode: runs from the current phase (which may be mid-instruction after phase steps) through WB inclusive. Then running=0 and phase=IF.
  - CONT mode: runs indefinitely. A stop pulse sets stop_pend; at the end of the next WB cycle, running=0, phase=IF, stop_pend=0. A stop arriving during WB stops at the end of that same WB.
- run while running: ignored. Mode level changes while running: ignored.
- inst_cnt increments at the end of every running WB cycle. It wraps from all-ones to 0.
- No X on any output after reset. All state lives in clock-edge registers; only cstate and inst_done are combinational.

Optional Feature:
- Macro: PHASEGEN_BREAK_EN.
- When defined, the block adds these ports:
  - `bp_en` input 1
  - `bp_addr` input 32
  - `pc` input 32
  - `bp_hit` output 1
- Breakpoint condition (bp_stop): CONT mode & running & phase==IF & bp_en & pc==bp_addr & not the first active cycle after start.
- On bp_stop:
  - cstate is forced to 0 in that cycle.
  - running clears at that edge; phase stays IF.
  - bp_hit is set and held sticky until the next accepted run.
- The first-cycle exclusion lets a run resume past the breakpoint.
- When undefined, the ports are absent and there is no breakpoint logic.

Test Plan:
1. Reset low mid-EX in CONT mode → cstate=0, phase=4'b0001, running=0 and inst_cnt=0 immediately, without waiting for a clock.
2. step_phase=1, run pulse from reset → next cycle cstate=0001 for exactly 1 cycle, then cstate=0000, phase=0010, inst_cnt=0.
3. After test 2, step_inst=1, run pulse → cstate 0010, 0100, 1000 over 3 cycles, then 0000. phase=0001, inst_cnt=1, inst_done high only in the 1000 cycle.
4. cont=1, run, let 10 full instructions (40 cycles) complete, then pulse stop during DE → continues through WB, stops with inst_cnt=11, phase=0001.
5. Simultaneous run+stop with cont=1 while idle → executes exactly one instruction (4 active cycles), then idle.
6. (PHASEGEN_BREAK_EN) bp_en=1, bp_addr=32'h10, pc reaches 32'h10 at IF in CONT → cstate=0 that cycle, running=0, bp_hit=1. A new run executes the IF at 32'h10 and clears bp_hit.
